srl32_fifo: RTL and testbench



---
 rtl/srl32_fifo.sv | 87 ++++++++
 tb/tb_srl32_fifo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/srl32_fifo.sv
// rtl/srl32_fifo.sv - 32-deep SRL32E-based FWFT FIFO; SRL32_FIFO_OREG_EN adds a registered output stage
module srl32_fifo #(
    parameter int WIDTH     = 8,
    parameter int AFULL_THR = 28
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DIN,
    output logic             FULL,
    output logic             AFULL,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic [5:0]       COUNT
);

    logic [5:0]       cnt;
    logic [4:0]       rd_addr;
    logic             wr_acc;
    logic             rd_acc;
    logic             pop;
    logic [WIDTH-1:0] srl_q;

    assign rd_addr = 5'(cnt - 6'd1);
    assign FULL    = (cnt == 6'd32);
    assign AFULL   = (cnt >= 6'(AFULL_THR));
    assign wr_acc  = WR_EN & ~FULL;
    assign rd_acc  = RD_EN & ~EMPTY;

    // One 32-bit shift register per data bit, no reset, shared CE and address: maps onto SRL32E
    for (genvar i = 0; i < WIDTH; i++) begin : g_srl
        logic [31:0] sr;
        always_ff @(posedge CLK) begin
            if (wr_acc) begin
                sr <= {sr[30:0], DIN[i]};
            end
        end
        assign srl_q[i] = sr[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 6'd0;
        end else begin
            case ({wr_acc, pop})
                2'b10:   cnt <= cnt + 6'd1;
                2'b01:   cnt <= cnt - 6'd1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef SRL32_FIFO_OREG_EN
    logic             ov;
    logic [WIDTH-1:0] dout_q;

    // Pull the oldest SRL word into the output register whenever it is free or being consumed
    assign pop = (cnt != 6'd0) & (~ov | rd_acc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ov <= 1'b0;
        end else if (pop) begin
            ov <= 1'b1;
        end else if (rd_acc) begin
            ov <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (pop) begin
            dout_q <= srl_q;
        end
    end

    assign EMPTY = ~ov;
    assign DOUT  = dout_q;
    assign COUNT = cnt + {5'd0, ov};
`else
    assign pop   = rd_acc;
    assign EMPTY = (cnt == 6'd0);
    assign DOUT  = srl_q;
    assign COUNT = cnt;
`endif

endmodule

// File: tb/tb_srl32_fifo.sv
// tb/tb_srl32_fifo.sv - directed self-checking bench for srl32_fifo
module tb_srl32_fifo;

`ifdef SRL32_FIFO_OREG_EN
    localparam bit OREG = 1'b1;
`else
    localparam bit OREG = 1'b0;
`endif
    localparam int NWORDS = 32 + int'(OREG);

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_EN;
    logic       RD_EN;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       FULL;
    logic       AFULL;
    logic       EMPTY;
    logic [5:0] COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    srl32_fifo #(.WIDTH(8), .AFULL_THR(28)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .WR_EN (WR_EN),
        .DIN   (DIN),
        .FULL  (FULL),
        .AFULL (AFULL),
        .RD_EN (RD_EN),
        .DOUT  (DOUT),
        .EMPTY (EMPTY),
        .COUNT (COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0] seq3 [3];
        int         cexp;
        seq3 = '{8'h11, 8'h22, 8'h33};

        RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; DIN = 8'h00;
        cyc(); cyc();
        RST = 1'b0;
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full",  32'(FULL),  32'd0);
        chk("rst_afull", 32'(AFULL), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);

        RD_EN = 1'b1;
        repeat (3) begin
            cyc();
            chk("underflow_count", 32'(COUNT), 32'd0);
            chk("underflow_empty", 32'(EMPTY), 32'd1);
        end
        RD_EN = 1'b0;

        WR_EN = 1'b1; DIN = 8'h11;
        cyc();
        chk("wr1_count", 32'(COUNT), 32'd1);
        chk("wr1_empty_latency", 32'(EMPTY), 32'(OREG));
        DIN = 8'h22;
        cyc();
        chk("wr2_count", 32'(COUNT), 32'd2);
        chk("wr2_empty", 32'(EMPTY), 32'd0);
        chk("wr2_dout",  32'(DOUT),  32'h11);
        DIN = 8'h33;
        cyc();
        chk("wr3_count", 32'(COUNT), 32'd3);
        WR_EN = 1'b0; RD_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pop_dout", 32'(DOUT), 32'(seq3[i]));
            cyc();
            chk("pop_count", 32'(COUNT), 32'(2 - i));
        end
        RD_EN = 1'b0;
        chk("pop_empty", 32'(EMPTY), 32'd1);

        WR_EN = 1'b1;
        for (int k = 1; k <= NWORDS; k++) begin
            DIN = 8'(k - 1);
            cyc();
            cexp = (OREG && k >= 2) ? k - 1 : k;
            chk("fill_count", 32'(COUNT), 32'(k));
            chk("fill_full",  32'(FULL),  32'(k == NWORDS));
            chk("fill_afull", 32'(AFULL), 32'(cexp >= 28));
        end
        DIN = 8'hAA;
        cyc();
        chk("ovf_count", 32'(COUNT), 32'(NWORDS));
        chk("ovf_full",  32'(FULL),  32'd1);
        WR_EN = 1'b0; RD_EN = 1'b1;
        for (int i = 0; i < NWORDS; i++) begin
            chk("drain_dout",  32'(DOUT),  32'(i));
            chk("drain_empty", 32'(EMPTY), 32'd0);
            cyc();
        end
        RD_EN = 1'b0;
        chk("drain_done_empty", 32'(EMPTY), 32'd1);
        chk("drain_done_count", 32'(COUNT), 32'd0);

        WR_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DIN = 8'(i);
            cyc();
        end
        chk("pre_count", 32'(COUNT), 32'd5);
        RD_EN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            DIN = 8'(5 + i);
            chk("rw_dout", 32'(DOUT), 32'(i));
            cyc();
            chk("rw_count", 32'(COUNT), 32'd5);
        end
        RD_EN = 1'b0;
        chk("rw_next_dout", 32'(DOUT), 32'd20);
        for (int i = 0; i < 5; i++) begin
            DIN = 8'(25 + i);
            cyc();
        end
        chk("ten_count", 32'(COUNT), 32'd10);

        RST = 1'b1; WR_EN = 1'b1; RD_EN = 1'b1; DIN = 8'hFF;
        cyc();
        RST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
        chk("midrst_count", 32'(COUNT), 32'd0);
        chk("midrst_empty", 32'(EMPTY), 32'd1);
        chk("midrst_full",  32'(FULL),  32'd0);
        WR_EN = 1'b1; DIN = 8'h5A;
        cyc();
        WR_EN = 1'b0;
        for (int t = 0; t < 4 && EMPTY; t++) cyc();
        chk("post_rst_visible", 32'(EMPTY), 32'd0);
        chk("post_rst_dout",    32'(DOUT),  32'h5A);
        chk("post_rst_count",   32'(COUNT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
